// File: rtl/ext_intr_gen_pkg.sv
// ext_intr_gen_pkg: shared channel state encoding, LFSR constants and draw helpers
// for the external-interrupt stimulus generator.
package ext_intr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2
  } ch_state_e;

  localparam logic [31:0] LFSR_POLY   = 32'h80200003;
  localparam logic [31:0] SEED_SPREAD = 32'h9E3779B9;
  localparam int unsigned STAT_CNT_W  = 16;

  // One step of the 32-bit Galois LFSR (right shift, feedback mask on bit 0).
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

  // Per-channel seed so channels loaded with one seed still diverge; never zero.
  function automatic logic [31:0] seed_spread(input logic [31:0] seed, input logic [31:0] idx);
    logic [31:0] v;
    v = seed ^ (idx * SEED_SPREAD);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  // Counter load for a random interval: min + low span bits of r, minus one
  // because the counter expires on the edge where it already reads zero.
  function automatic logic [31:0] span_draw(input int unsigned min_v, input int unsigned span_log2,
                                            input logic [31:0] r);
    logic [31:0] mask;
    mask = (32'd1 << span_log2) - 32'd1;
    return min_v + (r & mask) - 32'd1;
  endfunction

endpackage

// File: rtl/ext_intr_gen_ch.sv
// ext_intr_gen_ch: one interrupt channel -- LFSR, down-counter and IDLE/DELAY/ACTIVE FSM.
module ext_intr_gen_ch #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MIN_DLY       = 100,
  parameter int unsigned DLY_SPAN_LOG2 = 9,
  parameter int unsigned MIN_ON        = 100,
  parameter int unsigned ON_SPAN_LOG2  = 8,
  parameter logic [31:0] CH_IDX        = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        start_i,
  input  logic [31:0] seed_i,
  input  logic        seed_load_i,
  input  logic        level_mode_i,
  input  logic        periodic_i,
  input  logic        intr_clr_i,
  output logic        ext_intr_o,
  output logic        busy_o
);
  import ext_intr_gen_pkg::*;

  localparam logic [31:0] LFSR_RST = 32'h1 ^ CH_IDX;

  ch_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      lfsr_q, lfsr_d;
  logic             level_q, ext_intr_q;

  logic             cnt_zero, go_dly, go_act, act_end, draw;
  logic [31:0]      dly_full, on_full;
  logic [CNT_W-1:0] dly_cnt, on_cnt;

  // Both candidate counter loads come from the current LFSR value.
  assign dly_full = span_draw(MIN_DLY, DLY_SPAN_LOG2, lfsr_q);
  assign on_full  = span_draw(MIN_ON, ON_SPAN_LOG2, lfsr_q);
  assign dly_cnt  = dly_full[CNT_W-1:0];
  assign on_cnt   = on_full[CNT_W-1:0];

  assign cnt_zero = (cnt_q == '0);
  assign go_dly   = en_i && (state_q == ST_IDLE) && start_i;
  assign go_act   = en_i && (state_q == ST_DELAY) && cnt_zero;
  assign act_end  = en_i && (state_q == ST_ACTIVE) && (intr_clr_i || (!level_q && cnt_zero));
  // A draw happens only when a fresh interval is loaded.
  assign draw     = go_dly || (go_act && !level_mode_i) || (act_end && periodic_i);

  // LFSR next state: a seed load overrides a same-edge draw.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load_i)
      lfsr_d = seed_spread(seed_i, CH_IDX);
    else if (draw)
      lfsr_d = lfsr_step(lfsr_q);
  end

  // Channel FSM with registered interrupt output; en low parks the channel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lfsr_q     <= LFSR_RST;
      level_q    <= 1'b0;
      ext_intr_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      if (!en_i) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        level_q    <= 1'b0;
        ext_intr_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (go_dly) begin
              state_q <= ST_DELAY;
              cnt_q   <= dly_cnt;
            end
          end
          ST_DELAY: begin
            if (go_act) begin
              state_q    <= ST_ACTIVE;
              ext_intr_q <= 1'b1;
              level_q    <= level_mode_i;
              cnt_q      <= level_mode_i ? '0 : on_cnt;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (act_end) begin
              ext_intr_q <= 1'b0;
              if (periodic_i) begin
                state_q <= ST_DELAY;
                cnt_q   <= dly_cnt;
              end else begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
              end
            end else if (!level_q) begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ext_intr_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ext_intr_o = ext_intr_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: rtl/ext_intr_gen.sv
// ext_intr_gen: multi-channel pseudo-random external-interrupt stimulus generator.
// Define EXT_INTR_GEN_STAT_EN to add per-channel assertion count and longest-active stats.
module ext_intr_gen #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MIN_DLY       = 100,
  parameter int unsigned DLY_SPAN_LOG2 = 9,
  parameter int unsigned MIN_ON        = 100,
  parameter int unsigned ON_SPAN_LOG2  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [NUM_CH-1:0] start_i,
  input  logic [31:0]       seed_i,
  input  logic              seed_load_i,
  input  logic [NUM_CH-1:0] level_mode_i,
  input  logic [NUM_CH-1:0] periodic_i,
  input  logic [NUM_CH-1:0] intr_clr_i,
  output logic [NUM_CH-1:0] ext_intr_o,
  output logic              busy_o
`ifdef EXT_INTR_GEN_STAT_EN
  ,
  output logic [NUM_CH*16-1:0]    assert_cnt_o,
  output logic [NUM_CH*CNT_W-1:0] max_lat_o
`endif
);
  import ext_intr_gen_pkg::*;

  // Elaboration-time parameter sanity.
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_nch
    $error("ext_intr_gen: NUM_CH must be 1..16");
  end
  if (MIN_DLY < 1 || MIN_ON < 1) begin : g_bad_min
    $error("ext_intr_gen: MIN_DLY and MIN_ON must be >= 1");
  end
  if ((64'(MIN_DLY) + (64'd1 << DLY_SPAN_LOG2) - 64'd1) >= (64'd1 << CNT_W)) begin : g_bad_dly
    $error("ext_intr_gen: delay range does not fit CNT_W");
  end
  if ((64'(MIN_ON) + (64'd1 << ON_SPAN_LOG2) - 64'd1) >= (64'd1 << CNT_W)) begin : g_bad_on
    $error("ext_intr_gen: width range does not fit CNT_W");
  end

  logic [NUM_CH-1:0] ch_busy;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ext_intr_gen_ch #(
      .CNT_W        (CNT_W),
      .MIN_DLY      (MIN_DLY),
      .DLY_SPAN_LOG2(DLY_SPAN_LOG2),
      .MIN_ON       (MIN_ON),
      .ON_SPAN_LOG2 (ON_SPAN_LOG2),
      .CH_IDX       (32'(c))
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en_i        (en_i),
      .start_i     (start_i[c]),
      .seed_i      (seed_i),
      .seed_load_i (seed_load_i),
      .level_mode_i(level_mode_i[c]),
      .periodic_i  (periodic_i[c]),
      .intr_clr_i  (intr_clr_i[c]),
      .ext_intr_o  (ext_intr_o[c]),
      .busy_o      (ch_busy[c])
    );
  end

  assign busy_o = |ch_busy;

`ifdef EXT_INTR_GEN_STAT_EN
  logic [NUM_CH-1:0]                 intr_prev_q;
  logic [NUM_CH-1:0][STAT_CNT_W-1:0] acnt_q;
  logic [NUM_CH-1:0][CNT_W-1:0]      run_q, max_q;

  // Rising-edge counts and running/longest high time per channel; saturating.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      intr_prev_q <= '0;
      acnt_q      <= '0;
      run_q       <= '0;
      max_q       <= '0;
    end else begin
      intr_prev_q <= ext_intr_o;
      for (int c = 0; c < NUM_CH; c++) begin
        if (ext_intr_o[c] && !intr_prev_q[c] && (acnt_q[c] != '1))
          acnt_q[c] <= acnt_q[c] + 1'b1;
        if (ext_intr_o[c]) begin
          if (run_q[c] != '1) begin
            run_q[c] <= run_q[c] + 1'b1;
            if ((run_q[c] + 1'b1) > max_q[c])
              max_q[c] <= run_q[c] + 1'b1;
          end
        end else begin
          run_q[c] <= '0;
        end
      end
    end
  end

  assign assert_cnt_o = acnt_q;
  assign max_lat_o    = max_q;
`endif

endmodule

// File: tb/tb_ext_intr_gen.sv
// tb_ext_intr_gen: fixed-timing directed checks on a 1-channel instance and
// randomized seeded runs on a default 4-channel instance against a timing model.
module tb_ext_intr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // ---- DUT A: one channel, fixed delay 100 / width 50 ----
  logic        rst_a, en_a, start_a, seed_load_a, level_a, periodic_a, clr_a;
  logic [31:0] seed_a;
  logic        intr_a, busy_a;
`ifdef EXT_INTR_GEN_STAT_EN
  logic [15:0] acnt_a;
  logic [15:0] lat_a;
`endif

  ext_intr_gen #(
    .NUM_CH(1), .CNT_W(16), .MIN_DLY(100), .DLY_SPAN_LOG2(0), .MIN_ON(50), .ON_SPAN_LOG2(0)
  ) u_a (
    .clk_i(clk), .rst_i(rst_a), .en_i(en_a), .start_i(start_a), .seed_i(seed_a),
    .seed_load_i(seed_load_a), .level_mode_i(level_a), .periodic_i(periodic_a),
    .intr_clr_i(clr_a), .ext_intr_o(intr_a), .busy_o(busy_a)
`ifdef EXT_INTR_GEN_STAT_EN
    , .assert_cnt_o(acnt_a), .max_lat_o(lat_a)
`endif
  );

  // ---- DUT B: default parameters, four channels ----
  logic        rst_b, en_b, seed_load_b;
  logic [3:0]  start_b, level_b, periodic_b, clr_b;
  logic [31:0] seed_b;
  logic [3:0]  intr_b;
  logic        busy_b;
`ifdef EXT_INTR_GEN_STAT_EN
  logic [63:0] acnt_b;
  logic [63:0] lat_b;
`endif

  ext_intr_gen u_b (
    .clk_i(clk), .rst_i(rst_b), .en_i(en_b), .start_i(start_b), .seed_i(seed_b),
    .seed_load_i(seed_load_b), .level_mode_i(level_b), .periodic_i(periodic_b),
    .intr_clr_i(clr_b), .ext_intr_o(intr_b), .busy_o(busy_b)
`ifdef EXT_INTR_GEN_STAT_EN
    , .assert_cnt_o(acnt_b), .max_lat_o(lat_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Call from a negedge; returns at the negedge where cyc == n.
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Start pulse on DUT A; t is the edge that samples it.
  task automatic start_pulse_a(output int t);
    start_a = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  // ---- reference model ----
  function automatic logic [31:0] m_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
  endfunction

  function automatic logic [31:0] m_seed(input logic [31:0] s, input int c);
    logic [31:0] v;
    v = s ^ (32'(c) * 32'h9E3779B9);
    return (v == 0) ? 32'd1 : v;
  endfunction

  // ---- transition monitor for DUT B ----
  int rise_t[4][8];
  int fall_t[4][8];
  int rise_n[4];
  int fall_n[4];
  logic [3:0] prev_b = 4'b0;

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (intr_b[c] && !prev_b[c]) begin
        if (rise_n[c] < 8) rise_t[c][rise_n[c]] = cyc;
        rise_n[c]++;
      end
      if (!intr_b[c] && prev_b[c]) begin
        if (fall_n[c] < 8) fall_t[c][fall_n[c]] = cyc;
        fall_n[c]++;
      end
    end
    prev_b = intr_b;
  end

  int first_d[4];
  int first_w[4];

  // Seeded periodic run with random per-channel start offsets; each of the
  // first three pulses per channel must match the model's rise/fall edges.
  task automatic rand_run(input string tag, input logic [31:0] seed);
    int st[4];
    int off[4];
    int lim, t, d, w, prev;
    bit done;
    logic [31:0] l;
    en_b = 1'b0;
    @(negedge clk);
    seed_b = seed;
    seed_load_b = 1'b1;
    @(negedge clk);
    seed_load_b = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rise_n[c] = 0;
      fall_n[c] = 0;
      off[c] = $urandom_range(0, 15);
    end
    periodic_b = 4'hF;
    en_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      start_b = 4'b0;
      for (int c = 0; c < 4; c++)
        if (off[c] == i) begin
          start_b[c] = 1'b1;
          st[c] = cyc + 1;
        end
      @(negedge clk);
    end
    start_b = 4'b0;
    lim = cyc + 4000;
    done = 1'b0;
    while (!done && cyc < lim) begin
      @(negedge clk);
      done = (fall_n[0] >= 3) && (fall_n[1] >= 3) && (fall_n[2] >= 3) && (fall_n[3] >= 3);
    end
    chk({tag, "_timeout"}, 32'(done), 32'd1);
    en_b = 1'b0;
    @(negedge clk);
    chk({tag, "_en_off_busy"}, 32'(busy_b), 32'd0);
    if (done) begin
      for (int c = 0; c < 4; c++) begin
        l = m_seed(seed, c);
        t = st[c];
        prev = st[c];
        for (int k = 0; k < 3; k++) begin
          d = 100 + int'(l & 32'd511);
          l = m_step(l);
          w = 100 + int'(l & 32'd255);
          l = m_step(l);
          chk({tag, "_rise"}, 32'(rise_t[c][k]), 32'(t + d));
          chk({tag, "_fall"}, 32'(fall_t[c][k]), 32'(t + d + w));
          chk({tag, "_dly_range"},
              32'((rise_t[c][k] - prev) >= 100 && (rise_t[c][k] - prev) <= 611), 32'd1);
          chk({tag, "_on_range"},
              32'((fall_t[c][k] - rise_t[c][k]) >= 100 && (fall_t[c][k] - rise_t[c][k]) <= 355), 32'd1);
          if (k == 0) begin
            first_d[c] = rise_t[c][0] - st[c];
            first_w[c] = fall_t[c][0] - rise_t[c][0];
          end
          prev = fall_t[c][k];
          t = t + d + w;
        end
      end
    end
  endtask

  initial begin
    int t;
    bit differ;
    rst_a = 1'b1; en_a = 1'b1; start_a = 1'b0; seed_load_a = 1'b0; seed_a = 32'd0;
    level_a = 1'b0; periodic_a = 1'b0; clr_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0; start_b = 4'b0; seed_load_b = 1'b0; seed_b = 32'd0;
    level_b = 4'b0; periodic_b = 4'b0; clr_b = 4'b0;
    for (int c = 0; c < 4; c++) begin rise_n[c] = 0; fall_n[c] = 0; end
    #2;
    chk("rst_intr_a", 32'(intr_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_intr_b", 32'(intr_b), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
`ifdef EXT_INTR_GEN_STAT_EN
    chk("rst_acnt_a", 32'(acnt_a), 32'd0);
    chk("rst_lat_a", 32'(lat_a), 32'd0);
`endif
    @(negedge clk); @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // Fixed pulse; a second start during DELAY must not disturb timing.
    start_pulse_a(t);
    wait_cyc(t + 50);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_cyc(t + 99);  chk("pulse_pre_rise", 32'(intr_a), 32'd0);
    chk("pulse_busy_dly", 32'(busy_a), 32'd1);
    wait_cyc(t + 100); chk("pulse_rise", 32'(intr_a), 32'd1);
    wait_cyc(t + 149); chk("pulse_pre_fall", 32'(intr_a), 32'd1);
    wait_cyc(t + 150); chk("pulse_fall", 32'(intr_a), 32'd0);
    chk("pulse_busy_end", 32'(busy_a), 32'd0);
    wait_cyc(t + 160);
`ifdef EXT_INTR_GEN_STAT_EN
    chk("stat_acnt_1", 32'(acnt_a), 32'd1);
    chk("stat_lat_50", 32'(lat_a), 32'd50);
`endif

    // intr_clr on the very edge the width counter expires.
    start_pulse_a(t);
    wait_cyc(t + 149);
    chk("clr0_pre", 32'(intr_a), 32'd1);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("clr0_fall", 32'(intr_a), 32'd0);
    chk("clr0_busy", 32'(busy_a), 32'd0);
    wait_cyc(t + 151); chk("clr0_stays_low", 32'(intr_a), 32'd0);

    // Early clear in pulse mode.
    start_pulse_a(t);
    wait_cyc(t + 119);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("early_clr_fall", 32'(intr_a), 32'd0);
    chk("early_clr_busy", 32'(busy_a), 32'd0);
    wait_cyc(t + 125);
`ifdef EXT_INTR_GEN_STAT_EN
    chk("stat_acnt_3", 32'(acnt_a), 32'd3);
    chk("stat_lat_keep", 32'(lat_a), 32'd50);
`endif

    // Level mode held until clear at t+300.
    level_a = 1'b1;
    start_pulse_a(t);
    wait_cyc(t + 100); chk("lvl_rise", 32'(intr_a), 32'd1);
    wait_cyc(t + 299); chk("lvl_hold", 32'(intr_a), 32'd1);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("lvl_fall", 32'(intr_a), 32'd0);
    chk("lvl_busy", 32'(busy_a), 32'd0);
    level_a = 1'b0;
    wait_cyc(t + 305);
`ifdef EXT_INTR_GEN_STAT_EN
    chk("stat_lat_200", 32'(lat_a), 32'd200);
`endif

    // Periodic re-arm, then en dropped.
    periodic_a = 1'b1;
    start_pulse_a(t);
    wait_cyc(t + 100); chk("per_rise1", 32'(intr_a), 32'd1);
    wait_cyc(t + 249); chk("per_gap", 32'(intr_a), 32'd0);
    wait_cyc(t + 250); chk("per_rise2", 32'(intr_a), 32'd1);
    wait_cyc(t + 399); chk("per_gap2", 32'(intr_a), 32'd0);
    wait_cyc(t + 400); chk("per_rise3", 32'(intr_a), 32'd1);
    wait_cyc(t + 420); chk("per_high_420", 32'(intr_a), 32'd1);
    en_a = 1'b0;
    @(negedge clk);
    chk("en_off_intr", 32'(intr_a), 32'd0);
    chk("en_off_busy", 32'(busy_a), 32'd0);
    en_a = 1'b1;
    periodic_a = 1'b0;
    @(negedge clk);
`ifdef EXT_INTR_GEN_STAT_EN
    chk("stat_acnt_7", 32'(acnt_a), 32'd7);
`endif

    // Asynchronous reset while active; start held during reset is ignored.
    start_pulse_a(t);
    wait_cyc(t + 120);
    chk("rst_mid_pre", 32'(intr_a), 32'd1);
    rst_a = 1'b1;
    #1;
    chk("rst_mid_intr", 32'(intr_a), 32'd0);
    chk("rst_mid_busy", 32'(busy_a), 32'd0);
    start_a = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_a = 1'b0;
    start_a = 1'b0;
    t = cyc;
    wait_cyc(t + 110);
    chk("rst_start_ign", 32'(intr_a), 32'd0);
    chk("rst_start_busy", 32'(busy_a), 32'd0);
`ifdef EXT_INTR_GEN_STAT_EN
    chk("stat_rst_acnt", 32'(acnt_a), 32'd0);
`endif
    start_pulse_a(t);
    wait_cyc(t + 100); chk("post_rst_rise", 32'(intr_a), 32'd1);

    // Randomized seeded runs on the 4-channel instance.
    rand_run("rnd_s1", 32'd12345);
    rand_run("rnd_s2", 32'd12345);
    differ = 1'b0;
    for (int c = 1; c < 4; c++)
      if (first_d[c] != first_d[0] || first_w[c] != first_w[0]) differ = 1'b1;
    chk("ch_differ", 32'(differ), 32'd1);
    rand_run("rnd_rs", $urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
